// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Matrix geometry and key code width (code = row * 4 + col).
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    // Scanner FSM encoding; the numeric values are visible on the debug port.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Classify a column sample (active-low).
    // Returns {single, index}: single is set only when exactly one line is
    // low, and index is the position of that line. "none" and "multi" both
    // return single = 0, since ghost keys are not resolved.
    function automatic logic [2:0] onehot0_index(input logic [COLS-1:0] col);
        logic [2:0] res;
        res = 3'b000;
        case (col)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider that produces a one-cycle tick every SCAN_DIV clocks.
// The tick marks the last cycle of a scan slot. It is shared with the
// display multiplexer so that both paths step at the same cadence.
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..SCAN_DIV-1 and wrap. This never stalls, whatever the consumer is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Terminal count is the tick.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one row low at a time and samples the
// columns at the end of each row slot. It debounces press and release, and
// reports each accepted key once.
//
// Output handshake: key_valid is a single-cycle strobe with no back-pressure.
// The consumer must capture key_code in the cycle key_valid is high.
// key_code then holds that value until the next acceptance. key_held stays
// high from the acceptance cycle until the release has been debounced.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic [1:0]        dbg_state
);

    // Counter width is enough to hold DEBOUNCE_CNT itself.
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] REL_LAST = DW'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] S_SCAN = SCAN;
    localparam logic [1:0] S_DEB  = DEBOUNCE;
    localparam logic [1:0] S_HELD = HELD;

    logic            tick;
    logic [COLS-1:0] col_m;
    logic [COLS-1:0] col_s;
    logic [2:0]      dec;
    logic            single;
    logic [1:0]      cidx;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [1:0]      ridx;
    logic [1:0]      cand_row;
    logic [1:0]      cand_col;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   rel_cnt;

    logic            detect;
    logic            match;
    logic            accept;
    logic            reject;
    logic            release_ev;
    logic            advance;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous column lines (idle = all high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    // Column classification, used by every decision.
    assign dec    = onehot0_index(col_s);
    assign single = dec[2];
    assign cidx   = dec[1:0];

    // Scan events, each qualified by the tick so the lines have settled.
    always_comb begin
        detect     = 1'b0;
        match      = single && (cidx == cand_col);
        accept     = 1'b0;
        reject     = 1'b0;
        release_ev = 1'b0;
        if (tick) begin
            detect     = (state == S_SCAN) && single;
            accept     = (state == S_DEB) && match && (deb_cnt == DEB_LAST);
            reject     = (state == S_DEB) && !match;
            release_ev = (state == S_HELD) && !single && (rel_cnt == REL_LAST);
        end
        advance = (tick && (state == S_SCAN) && !single) || reject || release_ev;
    end

    // Next-state selection. Any unused encoding falls back to scanning.
    always_comb begin
        state_nx = state;
        case (state)
            S_SCAN:  if (detect)     state_nx = S_DEB;
            S_DEB:   if (accept)     state_nx = S_HELD;
                     else if (reject) state_nx = S_SCAN;
            S_HELD:  if (release_ev) state_nx = S_SCAN;
            default: state_nx = S_SCAN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SCAN;
        end else begin
            state <= state_nx;
        end
    end

    // Row index: it advances only when leaving a slot without a candidate.
    // While debouncing or holding, the row stays frozen on the candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ridx <= 2'd0;
        end else if (advance) begin
            ridx <= ridx + 2'd1;
        end
    end

    // Capture the candidate key at first detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_row <= 2'd0;
            cand_col <= 2'd0;
        end else if (detect) begin
            cand_row <= ridx;
            cand_col <= cidx;
        end
    end

    // Press debounce counter: 1 at detection, then +1 per matching tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
        end else if (detect) begin
            deb_cnt <= DW'(1);
        end else if (accept || reject) begin
            deb_cnt <= '0;
        end else if (tick && (state == S_DEB)) begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    // Release debounce counter: consecutive idle ticks while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_cnt <= '0;
        end else if (tick && (state == S_HELD)) begin
            if (single || release_ev) begin
                rel_cnt <= '0;
            end else begin
                rel_cnt <= rel_cnt + DW'(1);
            end
        end
    end

    // Registered key outputs: a one-cycle strobe on acceptance, and held until release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= {cand_row, cand_col};
                key_held <= 1'b1;
            end else if (release_ev) begin
                key_held <= 1'b0;
            end
        end
    end

    assign row       = ~(ROWS'(1) << ridx);
    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan. The bench has a physical keypad model that drives
// col from the pressed-key matrix and the active row. A reference model
// keeps the scan rules with plain integers, a queue holds expected key codes,
// and a per-cycle compare process checks the outputs against that model.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int ST_SCAN = 0;
    localparam int ST_DEB  = 1;
    localparam int ST_HELD = 2;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [1:0] dbg_state;

    // Keypad environment.
    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_col;
    logic [3:0]  kp_col;

    // Scoreboard and counters.
    logic [3:0] exp_q[$];
    int n_checks;
    int n_fail;
    int n_valid;
    bit chk_on;

    // Reference model state.
    int         m_k, m_idx, m_state, m_deb, m_rel, m_crow, m_ccol, m_code;
    bit         m_valid, m_held;
    logic [3:0] m_s1, m_s2;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dbg_state (dbg_state)
    );

    // Clock and reset: 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Keypad: each pressed key on the driven-low row pulls its column low.
    always_comb begin
        kp_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (row[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4 + c]) kp_col[c] = 1'b0;
                end
            end
        end
    end

    assign col = force_en ? force_col : kp_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Every clk cycle it works out what the scanner must do:
    // columns are seen two cycles late, a tick falls on every SCAN_DIV-th
    // cycle after reset, and the rows and debounce follow the scan rules.
    always @(posedge clk or posedge rst) begin : model
        logic [3:0] smp;
        int zeros;
        int ci;
        bit tk;
        if (rst) begin
            m_k = 0; m_s1 = 4'hf; m_s2 = 4'hf;
            m_idx = 0; m_state = ST_SCAN; m_deb = 0; m_rel = 0;
            m_crow = 0; m_ccol = 0; m_code = 0; m_valid = 0; m_held = 0;
            exp_q.delete();
        end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = col;
            tk   = ((m_k % SCAN_DIV) == SCAN_DIV - 1);
            m_k++;
            zeros = 0;
            ci    = 0;
            for (int c = 0; c < 4; c++) begin
                if (smp[c] == 1'b0) begin
                    zeros++;
                    ci = c;
                end
            end
            m_valid = 0;
            if (tk) begin
                if (m_state == ST_SCAN) begin
                    if (zeros == 1) begin
                        m_crow = m_idx; m_ccol = ci; m_deb = 1; m_state = ST_DEB;
                    end else begin
                        m_idx = (m_idx + 1) % 4;
                    end
                end else if (m_state == ST_DEB) begin
                    if (zeros == 1 && ci == m_ccol) begin
                        if (m_deb == DEBOUNCE_CNT) begin
                            m_code  = m_crow * 4 + m_ccol;
                            m_valid = 1; m_held = 1; m_deb = 0; m_state = ST_HELD;
                            exp_q.push_back(4'(m_code));
                        end else begin
                            m_deb++;
                        end
                    end else begin
                        m_deb = 0; m_idx = (m_idx + 1) % 4; m_state = ST_SCAN;
                    end
                end else begin
                    if (zeros == 1) m_rel = 0;
                    else m_rel++;
                    if (m_rel == DEBOUNCE_CNT) begin
                        m_held = 0; m_rel = 0; m_idx = (m_idx + 1) % 4; m_state = ST_SCAN;
                    end
                end
            end
        end
    end

    // Per-cycle compare on the falling edge, plus scoreboard pop on key_valid.
    always @(negedge clk) begin
        logic [3:0] exp_row;
        if (chk_on) begin
            exp_row = 4'b1111;
            exp_row[m_idx] = 1'b0;
            check("row", 32'(row), 32'(exp_row));
            check("key_code", 32'(key_code), 32'(m_code));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_held", 32'(key_held), 32'(m_held));
            check("state", 32'(dbg_state), 32'(m_state));
            if (key_valid === 1'b1) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got key_valid with code %0h, expected no key", key_code);
                end else begin
                    check("sb_code", 32'(key_code), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max);
        int i;
        i = 0;
        @(negedge clk);
        while (key_valid !== 1'b1 && i < max) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got no key_valid within %0d cycles, expected a pulse", name, max);
        end
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Stimulus sequence.
    initial begin : stim
        int v0;
        n_checks = 0; n_fail = 0; n_valid = 0; chk_on = 0;
        pressed = '0; force_en = 1'b0; force_col = 4'hf;
        rst = 1'b0;

        // Reset asserted mid-cycle: outputs must clear immediately.
        #3 rst = 1'b1;
        #1;
        chk_on = 1;
        check("rst_row", 32'(row), 32'h0000000e);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        release_reset();

        // Row rotation, one step every SCAN_DIV cycles.
        repeat (4) @(posedge clk); @(negedge clk);
        check("rot_1", 32'(row), 32'h0000000d);
        repeat (4) @(posedge clk); @(negedge clk);
        check("rot_2", 32'(row), 32'h0000000b);
        repeat (4) @(posedge clk); @(negedge clk);
        check("rot_3", 32'(row), 32'h00000007);
        repeat (4) @(posedge clk); @(negedge clk);
        check("rot_4", 32'(row), 32'h0000000e);

        // Clean press on row 1 / col 2, held for a long time.
        v0 = n_valid;
        pressed[6] = 1'b1;
        wait_valid("press6", 60);
        check("press6_code", 32'(key_code), 32'd6);
        check("press6_held", 32'(key_held), 32'd1);
        check("press6_row", 32'(row), 32'h0000000d);
        cycles(80);
        check("press6_once", 32'(n_valid - v0), 32'd1);
        check("press6_frozen", 32'(row), 32'h0000000d);

        // Release: two idle ticks, one pressed tick, then three idle ticks.
        v0 = n_valid;
        pressed[6] = 1'b0; cycles(8);
        pressed[6] = 1'b1; cycles(4);
        pressed[6] = 1'b0; cycles(4);
        check("rel_still_held", 32'(key_held), 32'd1);
        cycles(12);
        check("rel_dropped", 32'(key_held), 32'd0);
        check("rel_no_valid", 32'(n_valid - v0), 32'd0);
        check("rel_scan", 32'(dbg_state), 32'(ST_SCAN));

        // Bounce on key 9: alternate every tick, never accepted.
        v0 = n_valid;
        for (int b = 0; b < 12; b++) begin
            pressed[9] = ~pressed[9];
            cycles(4);
        end
        pressed[9] = 1'b0;
        cycles(8);
        check("bounce_no_valid", 32'(n_valid - v0), 32'd0);
        pressed[9] = 1'b1;
        wait_valid("bounce_then_stable", 60);
        check("bounce_code", 32'(key_code), 32'd9);
        pressed[9] = 1'b0;
        cycles(40);
        check("bounce_released", 32'(key_held), 32'd0);

        // Multi-key on row 0 (col = 0011): ignored.
        v0 = n_valid;
        pressed[2] = 1'b1; pressed[3] = 1'b1;
        cycles(60);
        check("multi_no_valid", 32'(n_valid - v0), 32'd0);
        check("multi_scan", 32'(dbg_state), 32'(ST_SCAN));
        pressed = '0;
        cycles(8);

        // Corner key 15, then reset while held.
        pressed[15] = 1'b1;
        wait_valid("press15", 60);
        check("press15_code", 32'(key_code), 32'd15);
        cycles(10);
        reset_mid_cycle();
        check("hold_rst_held", 32'(key_held), 32'd0);
        check("hold_rst_state", 32'(dbg_state), 32'(ST_SCAN));
        check("hold_rst_row", 32'(row), 32'h0000000e);
        check("hold_rst_code", 32'(key_code), 32'd0);
        pressed = '0;
        release_reset();
        cycles(8);

        // Randomized traffic checked by the model every cycle.
        for (int it = 0; it < 30; it++) begin
            int key;
            int mode;
            int nb;
            key  = $urandom_range(0, 15);
            mode = $urandom_range(0, 4);
            case (mode)
                0: begin
                    pressed[key] = 1'b1;
                    cycles($urandom_range(40, 90));
                end
                1: begin
                    pressed[key] = 1'b1;
                    cycles($urandom_range(1, 14));
                end
                2: begin
                    nb = $urandom_range(4, 10);
                    for (int b = 0; b < nb; b++) begin
                        pressed[key] = ~pressed[key];
                        cycles($urandom_range(2, 9));
                    end
                end
                3: begin
                    pressed[key] = 1'b1;
                    pressed[$urandom_range(0, 15)] = 1'b1;
                    cycles($urandom_range(30, 80));
                end
                default: begin
                    force_en = 1'b1;
                    nb = $urandom_range(4, 20);
                    for (int b = 0; b < nb; b++) begin
                        force_col = 4'($urandom);
                        cycles($urandom_range(1, 6));
                    end
                    force_en = 1'b0;
                end
            endcase
            pressed = '0;
            if ($urandom_range(0, 9) == 0) begin
                reset_mid_cycle();
                check("rand_rst_held", 32'(key_held), 32'd0);
                release_reset();
            end
            cycles($urandom_range(30, 50));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
